// File: rtl/toysram_port_arb.sv
// Port arbiter/sequencer for the 32x32 toy SRAM: shares the single array port
// between the Wishbone slave and the logic-analyzer requester.
module toysram_port_arb #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter logic [7:0]  CTRL_OFS = 8'h80
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        la_req_i,
    input  logic        la_we_i,
    input  logic [4:0]  la_adr_i,
    input  logic [31:0] la_dat_i,
    output logic        la_ack_o,
    output logic [31:0] la_dat_o,
    output logic        arr_rd_o,
    output logic        arr_wr_o,
    output logic [4:0]  arr_adr_o,
    output logic [3:0]  arr_wbe_o,
    output logic [31:0] arr_dat_o,
    input  logic [31:0] arr_dat_i
);

    localparam logic [31:0] CTRL_ADR = BASE_ADR + {24'b0, CTRL_OFS};

    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  ctrl;       // bit0 la_en, bit1 wb_fixed
    logic        last_wb;    // last array grant went to Wishbone
    logic        gnt_wb;     // current transaction belongs to Wishbone
    logic        cmd_we;

    logic        wb_arr;
    logic        wb_ctl;
    logic        la_act;
    logic        pick_wb;
    logic        pick_la;

    assign wb_arr  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:7] == BASE_ADR[31:7]);
    assign wb_ctl  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i == CTRL_ADR);
    assign la_act  = la_req_i & ctrl[0];
    // Wishbone wins when alone, when fixed priority is set, or when LA had the last grant.
    assign pick_wb = wb_arr & (~la_act | ctrl[1] | ~last_wb);
    assign pick_la = la_act & ~pick_wb;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) state <= IDLE;
        else           state <= next_state;
    end

    always_comb begin
        next_state = state;
        wbs_ack_o  = 1'b0;
        la_ack_o   = 1'b0;
        case (state)
            IDLE: begin
                if (wb_ctl)                 next_state = RESP;
                else if (pick_wb | pick_la) next_state = CMD;
            end
            CMD:  next_state = RESP;
            RESP: begin
                next_state = IDLE;
                // An abandoned Wishbone cycle still completes on the array but is not acked.
                wbs_ack_o  = gnt_wb & wbs_cyc_i & wbs_stb_i;
                la_ack_o   = ~gnt_wb;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            ctrl      <= 2'b01;
            last_wb   <= 1'b0;
            gnt_wb    <= 1'b0;
            cmd_we    <= 1'b0;
            arr_rd_o  <= 1'b0;
            arr_wr_o  <= 1'b0;
            arr_adr_o <= '0;
            arr_wbe_o <= '0;
            arr_dat_o <= '0;
            wbs_dat_o <= '0;
            la_dat_o  <= '0;
        end else begin
            arr_rd_o <= 1'b0;
            arr_wr_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_ctl) begin
                        gnt_wb <= 1'b1;
                        if (wbs_we_i && wbs_sel_i[0]) ctrl <= wbs_dat_i[1:0];
                        if (!wbs_we_i)                wbs_dat_o <= {30'b0, ctrl};
                    end else if (pick_wb) begin
                        gnt_wb    <= 1'b1;
                        last_wb   <= 1'b1;
                        cmd_we    <= wbs_we_i;
                        arr_rd_o  <= ~wbs_we_i;
                        arr_wr_o  <= wbs_we_i;
                        arr_adr_o <= wbs_adr_i[6:2];
                        arr_wbe_o <= wbs_we_i ? wbs_sel_i : 4'h0;
                        arr_dat_o <= wbs_dat_i;
                    end else if (pick_la) begin
                        gnt_wb    <= 1'b0;
                        last_wb   <= 1'b0;
                        cmd_we    <= la_we_i;
                        arr_rd_o  <= ~la_we_i;
                        arr_wr_o  <= la_we_i;
                        arr_adr_o <= la_adr_i;
                        arr_wbe_o <= la_we_i ? 4'hF : 4'h0;
                        arr_dat_o <= la_dat_i;
                    end
                end
                CMD: begin
                    if (!cmd_we) begin
                        if (gnt_wb) wbs_dat_o <= arr_dat_i;
                        else        la_dat_o  <= arr_dat_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
